// File: rtl/rv_pkg.sv
// Shared RV32 encoder definitions: opcodes, instruction formats, FSM states
// and the immediate sign-extension check used by the packer.
package rv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_R,
        FMT_SB,
        FMT_ILL
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic fmt_e decode_fmt(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_LOAD, OP_IMM: f = FMT_I;
            OP_STORE:        f = FMT_S;
            OP_REG:          f = FMT_R;
            OP_BRANCH:       f = FMT_SB;
            default:         f = FMT_ILL;
        endcase
        return f;
    endfunction

    // True when imm[63:msb] are all equal, i.e. the value fits a signed field
    // whose sign bit sits at position msb.
    function automatic logic sext_ok(input logic [63:0] imm, input int unsigned msb);
        logic [63:0] t;
        t = $signed(imm) >>> msb;
        return (t == '0) || (t == '1);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Instruction-input channel and instruction-memory write channel of the
// encoder; "slave" is the encoder's view, "master" the producer/memory side.
interface instr_encoder_if #(
    parameter int ADDR_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [63:0]       imm;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_last, opcode, rd, rs1, rs2, funct3, funct7, imm, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_last, opcode, rd, rs1, rs2, funct3, funct7, imm, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_pack.sv
// Combinational format decode, field packing and immediate range check for
// one instruction; illegal opcodes never raise a range error.
module instr_pack
    import rv_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [63:0] imm_i,
    output logic [31:0] word_o,
    output logic        err_op_o,
    output logic        err_range_o
);

    always_comb begin
        word_o      = '0;
        err_op_o    = 1'b0;
        err_range_o = 1'b0;
        case (decode_fmt(opcode_i))
            FMT_I: begin
                word_o      = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                err_range_o = !sext_ok(imm_i, 11);
            end
            FMT_S: begin
                word_o      = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                err_range_o = !sext_ok(imm_i, 11);
            end
            FMT_R: begin
                word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
            FMT_SB: begin
                // Branch offsets are byte offsets to halfword-aligned targets.
                word_o      = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                               imm_i[4:1], imm_i[11], opcode_i};
                err_range_o = !sext_ok(imm_i, 12) || imm_i[0];
            end
            default: err_op_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Load-session controller: accepts instruction fields, packs them and writes
// the words to consecutive instruction-memory addresses through one output stage.
module instr_encoder
    import rv_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    instr_encoder_if.slave    bus,
    output logic              busy,
    output logic              done,
    output logic              err_range,
    output logic              err_op,
    output logic [15:0]       count
);

    state_e            state_q, state_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [15:0]       count_q, count_d;
    logic              err_range_q, err_range_d;
    logic              err_op_q, err_op_d;

    logic        in_ready;
    logic        xfer;
    logic        wr_done;
    logic [31:0] pack_word;
    logic        pack_err_op;
    logic        pack_err_range;

    instr_pack u_pack (
        .opcode_i    (bus.opcode),
        .rd_i        (bus.rd),
        .rs1_i       (bus.rs1),
        .rs2_i       (bus.rs2),
        .funct3_i    (bus.funct3),
        .funct7_i    (bus.funct7),
        .imm_i       (bus.imm),
        .word_o      (pack_word),
        .err_op_o    (pack_err_op),
        .err_range_o (pack_err_range)
    );

    assign xfer    = bus.in_valid && in_ready;
    assign wr_done = mem_we_q && bus.mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            addr_cnt_q  <= '0;
            count_q     <= '0;
            err_range_q <= 1'b0;
            err_op_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            addr_cnt_q  <= addr_cnt_d;
            count_q     <= count_d;
            err_range_q <= err_range_d;
            err_op_q    <= err_op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  if (xfer && bus.in_last) state_d = ST_DRAIN;
            ST_DRAIN: if (!mem_we_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
        done     = (state_q == ST_DONE);
        in_ready = (state_q == ST_LOAD) && (!mem_we_q || bus.mem_ready);
    end

    // addr_cnt_q always names the address of the word in (or next entering)
    // the output stage, so a load that overlaps a completion uses cnt+4.
    always_comb begin
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        addr_cnt_d  = addr_cnt_q;
        count_d     = count_q;
        err_range_d = err_range_q;
        err_op_d    = err_op_q;

        if (state_q == ST_IDLE && start) begin
            addr_cnt_d  = base_addr;
            count_d     = '0;
            err_range_d = 1'b0;
            err_op_d    = 1'b0;
        end

        if (wr_done) begin
            mem_we_d   = 1'b0;
            addr_cnt_d = addr_cnt_q + ADDR_W'(4);
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end

        if (xfer) begin
            if (pack_err_op) begin
                err_op_d = 1'b1;
            end else if (pack_err_range) begin
                err_range_d = 1'b1;
            end else begin
                mem_we_d    = 1'b1;
                mem_addr_d  = wr_done ? addr_cnt_q + ADDR_W'(4) : addr_cnt_q;
                mem_wdata_d = pack_word;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign err_range     = err_range_q;
    assign err_op        = err_op_q;
    assign count         = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: one task per scenario, expected words
// hand-encoded from the RV32 I/S/R/SB field layouts.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] base_addr;
    logic        busy, done, err_range, err_op;
    logic [15:0] count;

    int checks = 0;
    int errors = 0;

    instr_encoder_if #(.ADDR_W(64)) bus ();

    instr_encoder #(.ADDR_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err_range (err_range),
        .err_op    (err_op),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [63:0] imm, input logic last);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.rd       = rd;
        bus.rs1      = rs1;
        bus.rs2      = rs2;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.imm      = imm;
        bus.in_last  = last;
        $display("txn op=%b rd=%0d rs1=%0d rs2=%0d f3=%b f7=%b imm=%h last=%0b",
                 op, rd, rs1, rs2, f3, f7, imm, last);
    endtask

    task automatic idle_in();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic start_session(input logic [63:0] base);
        start     = 1'b1;
        base_addr = base;
        step();
        start = 1'b0;
    endtask

    // Steps until done is seen (ok=1) or the budget runs out, then one more
    // cycle so the FSM is back in IDLE.
    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 64'h0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", bus.mem_wdata); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", bus.in_ready); end
        checks++; if ({busy, done, err_range, err_op} !== 4'b0000) begin errors++; $display("FAIL reset_status got %b want 0000", {busy, done, err_range, err_op}); end
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        reset = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b want 0", busy); end
    endtask

    task automatic test_addi();
        bit ok;
        bus.mem_ready = 1'b1;
        start_session(64'h100);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL addi_busy got %0b want 1", busy); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL addi_in_ready got %0b want 1", bus.in_ready); end
        drive(7'b0010011, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        step();
        idle_in();
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL addi_we got %0b want 1", bus.mem_we); end
        checks++; if (bus.mem_addr !== 64'h100) begin errors++; $display("FAIL addi_addr got %h want 100", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'hFFF10093) begin errors++; $display("FAIL addi_wdata got %h want fff10093", bus.mem_wdata); end
        step();
        checks++; if (count !== 16'd1) begin errors++; $display("FAIL addi_count got %0d want 1", count); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL addi_done got timeout want pulse"); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        start_session(64'h100);
        // start during LOAD must not reload the address counter
        start     = 1'b1;
        base_addr = 64'h999;
        drive(7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 64'd8, 1'b0);
        step();
        start = 1'b0;
        checks++; if (bus.mem_wdata !== 32'h00512423) begin errors++; $display("FAIL sw_wdata got %h want 00512423", bus.mem_wdata); end
        checks++; if (bus.mem_addr !== 64'h100) begin errors++; $display("FAIL sw_addr got %h want 100", bus.mem_addr); end
        drive(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 64'h0, 1'b1);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %0b want 1", bus.in_ready); end
        step();
        idle_in();
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL add_we got %0b want 1", bus.mem_we); end
        checks++; if (bus.mem_wdata !== 32'h002081B3) begin errors++; $display("FAIL add_wdata got %h want 002081b3", bus.mem_wdata); end
        checks++; if (bus.mem_addr !== 64'h104) begin errors++; $display("FAIL add_addr got %h want 104", bus.mem_addr); end
        step();
        checks++; if (count !== 16'd2) begin errors++; $display("FAIL b2b_count got %0d want 2", count); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_done got timeout want pulse"); end
    endtask

    task automatic test_branch_last();
        start_session(64'h200);
        drive(7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        step();
        idle_in();
        checks++; if (bus.mem_wdata !== 32'hFE000EE3) begin errors++; $display("FAIL beq_wdata got %h want fe000ee3", bus.mem_wdata); end
        checks++; if (bus.mem_addr !== 64'h200) begin errors++; $display("FAIL beq_addr got %h want 200", bus.mem_addr); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL drain_in_ready got %0b want 0", bus.in_ready); end
        step();
        checks++; if ({busy, done, bus.mem_we} !== 3'b100) begin errors++; $display("FAIL drain_state got busy/done/we=%b want 100", {busy, done, bus.mem_we}); end
        step();
        checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL done_pulse got busy/done=%b want 01", {busy, done}); end
        step();
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL back_idle got busy/done=%b want 00", {busy, done}); end
    endtask

    task automatic test_errors();
        bit ok;
        start_session(64'h300);
        drive(7'b0010011, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 64'd2048, 1'b0);
        step();
        checks++; if ({bus.mem_we, err_range, err_op} !== 3'b010) begin errors++; $display("FAIL imm2048 got we/rng/op=%b want 010", {bus.mem_we, err_range, err_op}); end
        drive(7'b0000000, 5'd1, 5'd2, 5'd3, 3'b000, 7'd0, 64'd0, 1'b0);
        step();
        checks++; if ({bus.mem_we, err_range, err_op} !== 3'b011) begin errors++; $display("FAIL badop got we/rng/op=%b want 011", {bus.mem_we, err_range, err_op}); end
        checks++; if (bus.mem_addr !== 64'h200) begin errors++; $display("FAIL err_addr got %h want 200", bus.mem_addr); end
        drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 64'd3, 1'b0);
        step();
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL odd_branch_we got %0b want 0", bus.mem_we); end
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL err_count got %0d want 0", count); end
        drive(7'b0000011, 5'd7, 5'd8, 5'd0, 3'b010, 7'd0, 64'd4, 1'b1);
        step();
        idle_in();
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL lw_we got %0b want 1", bus.mem_we); end
        checks++; if (bus.mem_addr !== 64'h300) begin errors++; $display("FAIL lw_addr got %h want 300", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h00442383) begin errors++; $display("FAIL lw_wdata got %h want 00442383", bus.mem_wdata); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL err_done got timeout want pulse"); end
        checks++; if ({err_range, err_op} !== 2'b11) begin errors++; $display("FAIL sticky got rng/op=%b want 11", {err_range, err_op}); end
    endtask

    task automatic test_stall_reset();
        start_session(64'h400);
        checks++; if ({err_range, err_op} !== 2'b00) begin errors++; $display("FAIL start_clear got rng/op=%b want 00", {err_range, err_op}); end
        bus.mem_ready = 1'b0;
        drive(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 64'h0, 1'b0);
        step();
        drive(7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 64'd8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.mem_we, bus.in_ready} !== 2'b10 || bus.mem_addr !== 64'h400 || bus.mem_wdata !== 32'h002081B3) begin
                errors++;
                $display("FAIL stall_%0d got we/rdy=%b addr=%h wdata=%h want 10 400 002081b3",
                         i, {bus.mem_we, bus.in_ready}, bus.mem_addr, bus.mem_wdata);
            end
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle_in();
        bus.mem_ready = 1'b1;
        checks++; if ({bus.mem_we, bus.in_ready, busy, done} !== 4'b0000) begin errors++; $display("FAIL stall_reset_ctl got we/rdy/busy/done=%b want 0000", {bus.mem_we, bus.in_ready, busy, done}); end
        checks++; if (bus.mem_addr !== 64'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL stall_reset_data got addr=%h wdata=%h want 0 0", bus.mem_addr, bus.mem_wdata); end
        checks++; if ({err_range, err_op, count} !== 18'h0) begin errors++; $display("FAIL stall_reset_cnt got rng/op=%b count=%0d want 00 0", {err_range, err_op}, count); end
        step();
        checks++; if (bus.mem_we !== 1'b0 || count !== 16'd0) begin errors++; $display("FAIL after_reset got we=%0b count=%0d want 0 0", bus.mem_we, count); end
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        base_addr     = '0;
        bus.mem_ready = 1'b1;
        bus.opcode    = '0;
        bus.rd        = '0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.funct3    = '0;
        bus.funct7    = '0;
        bus.imm       = '0;
        idle_in();
        test_reset();
        test_addi();
        test_back_to_back();
        test_branch_last();
        test_errors();
        test_stall_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
